// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray-code helpers for the async FIFO pointer stages.
// Helpers work at the widest pointer width; narrower callers zero-extend and truncate.
package fifo_pkg;

  localparam int DEF_PTR_LEN = 8;

  typedef logic [DEF_PTR_LEN:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ {1'b0, bin[DEF_PTR_LEN:1]};
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin = gray;
    for (int i = DEF_PTR_LEN - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop clock-domain synchroniser with asynchronous active-low reset.
// Pure flop chain: nothing sits between stages, so it is safe for Gray-coded buses.
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift chain; first stage captures the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/wr_full_gen.sv
// Write-domain status stage of the async FIFO: publishes the Gray write pointer and
// derives registered full / almost_full / fill level against the synchronised read pointer.
module wr_full_gen
  import fifo_pkg::*;
#(
  parameter int PTR_LEN     = fifo_pkg::DEF_PTR_LEN,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 2
) (
  input  logic             wclk,
  input  logic             wr_srstn,
  input  logic             wr_en,
  input  logic [PTR_LEN:0] wrt_ptr,
  input  logic [PTR_LEN:0] rd_ptr_gray,
  output logic [PTR_LEN:0] wr_ptr_gray,
  output logic             full,
  output logic             almost_full,
  output logic [PTR_LEN:0] wr_count
);

  localparam int               PTR_W     = PTR_LEN + 1;
  localparam logic [PTR_LEN:0] DEPTH     = {1'b1, {PTR_LEN{1'b0}}};
  localparam logic [PTR_LEN:0] AF_T      = PTR_W'(AF_THRESH);
  // Full pattern differs from the read pointer in exactly the top two Gray bits.
  localparam logic [PTR_LEN:0] TOP2_MASK = ~({PTR_W{1'b1}} >> 2'd2);

  logic [PTR_LEN:0] rq;
  logic [PTR_LEN:0] rbin;
  logic [PTR_LEN:0] wptr_nxt;
  logic [PTR_LEN:0] gray_d;
  logic [PTR_LEN:0] count_d;
  logic [PTR_LEN:0] free_slots;
  logic             wr_inc;
  logic             full_d;
  logic             almost_full_d;

  logic [PTR_LEN:0] wr_ptr_gray_q;
  logic [PTR_LEN:0] wr_count_q;
  logic             full_q;
  logic             almost_full_q;

  sync_ff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd2wr_sync (
    .clk_i  (wclk),
    .rst_ni (wr_srstn),
    .d_i    (rd_ptr_gray),
    .q_o    (rq)
  );

  // Next-pointer arithmetic and status derivation from the synchronised read pointer.
  always_comb begin
    wr_inc        = wr_en & ~full_q;
    wptr_nxt      = wrt_ptr + {{PTR_LEN{1'b0}}, wr_inc};
    gray_d        = PTR_W'(bin2gray(ptr_t'(wptr_nxt)));
    rbin          = PTR_W'(gray2bin(ptr_t'(rq)));
    full_d        = (gray_d == (rq ^ TOP2_MASK));
    count_d       = wptr_nxt - rbin;
    free_slots    = DEPTH - count_d;
    almost_full_d = (free_slots <= AF_T);
  end

  // Status registers; wr_ptr_gray_q is the only flop seen by the read domain.
  always_ff @(posedge wclk or negedge wr_srstn) begin
    if (!wr_srstn) begin
      wr_ptr_gray_q <= {PTR_W{1'b0}};
      wr_count_q    <= {PTR_W{1'b0}};
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_gray_q <= gray_d;
      wr_count_q    <= count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign wr_ptr_gray = wr_ptr_gray_q;
  assign wr_count    = wr_count_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;

endmodule
